// File: rtl/rom_stream_reader.sv
// rom_stream_reader: streams a burst of consecutive ROM words through a small output FIFO.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [ADDR_WIDTH:0] iss_left;
  logic [RD_LATENCY-1:0] pipe_vld, pipe_last;
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] in_flight;
  logic issue, push, pop, flush, drain_done;
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + IW'(pipe_vld[i]);
  end
  // Reads are only issued when their data is guaranteed a FIFO slot, so the FIFO never overflows.
  assign issue = state == RUN && !abort && (int'(count) + int'(in_flight) < FIFO_DEPTH);
  assign flush = abort && (state == RUN || state == DRAIN);
  assign push = pipe_vld[RD_LATENCY-1];
  assign pop = m_valid && m_ready;
  assign drain_done = in_flight == '0 && (count == '0 || (count == CW'(1) && pop));
  assign head = mem[rd_ptr];
  assign m_valid = count != '0;
  assign m_data = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_last = m_valid && head[DATA_WIDTH];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (word_cnt == '0 ? DONE : RUN) : IDLE;
      RUN:     state_nxt = abort ? IDLE : (issue && iss_left == (ADDR_WIDTH+1)'(1)) ? DRAIN : RUN;
      DRAIN:   state_nxt = abort ? IDLE : drain_done ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr <= '0;
      nxt_addr <= '0;
      iss_left <= '0;
      pipe_vld <= '0;
      pipe_last <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (state == IDLE && start) begin
        nxt_addr <= base_addr;
        iss_left <= word_cnt;
      end
      if (issue) begin
        rom_addr <= nxt_addr;
        nxt_addr <= nxt_addr + ADDR_WIDTH'(1);
        iss_left <= iss_left - (ADDR_WIDTH+1)'(1);
      end
      pipe_vld[0] <= issue;
      pipe_last[0] <= issue && iss_left == (ADDR_WIDTH+1)'(1);
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      if (flush) begin
        pipe_vld <= '0;
        pipe_last <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {pipe_last[RD_LATENCY-1], rom_rd_data};
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: two readers (read latency 1 and 2) share stimulus; a queue scoreboard checks every beat.
module tb_rom_stream_reader;
  logic clk = 1'b0;
  logic rst_n, start, abort, m_ready;
  logic [9:0] base_addr;
  logic [10:0] word_cnt;
  logic busy0, done0, m_valid0, m_last0, busy1, done1, m_valid1, m_last1;
  logic [9:0] rom_addr0, rom_addr1;
  logic [31:0] rd0, rd1, m_data0, m_data1;
  logic [32:0] q0[$], q1[$];
  int checks = 0, failures = 0, cyc = 0, start_cyc = 0;
  int first_cyc[2], last_cyc[2], done_cyc[2], done_n[2], busy_n[2], hs_n[2];

  initial forever #5 clk = ~clk;

  rom_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr), .word_cnt(word_cnt),
    .busy(busy0), .done(done0), .rom_addr(rom_addr0), .rom_rd_data(rd0),
    .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready));
  rom_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr), .word_cnt(word_cnt),
    .busy(busy1), .done(done1), .rom_addr(rom_addr1), .rom_rd_data(rd1),
    .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1), .m_ready(m_ready));

  // ROM contents are a fixed function of the address; the latency-2 ROM has an output register.
  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return {6'h2b, a, 6'h15, a};
  endfunction
  assign rd0 = rom_word(rom_addr0);
  always @(posedge clk) rd1 <= rom_word(rom_addr1);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic mon_lane(input int l, input logic v, input logic lst, input logic [31:0] d,
                          input logic rdy, input logic bz, input logic dn);
    logic [32:0] e;
    int sz;
    sz = (l == 0) ? q0.size() : q1.size();
    if (bz) busy_n[l]++;
    if (dn) begin
      done_n[l]++;
      done_cyc[l] = cyc;
      check($sformatf("done_before_last%0d", l), 64'(sz), 0);
    end
    if (v && sz == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_beat%0d got=%0h exp=none", l, d);
    end else if (v) begin
      e = (l == 0) ? q0[0] : q1[0];
      check($sformatf("beat%0d", l), 64'({lst, d}), 64'(e));
      if (rdy) begin
        if (l == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        hs_n[l]++;
        if (first_cyc[l] < 0) first_cyc[l] = cyc;
        last_cyc[l] = cyc;
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      mon_lane(0, m_valid0, m_last0, m_data0, m_ready, busy0, done0);
      mon_lane(1, m_valid1, m_last1, m_data1, m_ready, busy1, done1);
    end
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_ctl0"}, 64'({busy0, done0, m_valid0, m_last0, rom_addr0}), 0);
    check({tag, "_data0"}, 64'(m_data0), 0);
    check({tag, "_ctl1"}, 64'({busy1, done1, m_valid1, m_last1, rom_addr1}), 0);
    check({tag, "_data1"}, 64'(m_data1), 0);
  endtask

  // Scoreboard expectation: word k of the burst is ROM[(b+k) mod 1024], the last one flagged.
  task automatic issue_start(input logic [9:0] b, input logic [10:0] n);
    for (int l = 0; l < 2; l++) begin
      first_cyc[l] = -1; last_cyc[l] = -1; done_cyc[l] = -1;
      done_n[l] = 0; busy_n[l] = 0; hs_n[l] = 0;
    end
    for (int k = 0; k < int'(n); k++) begin
      q0.push_back({k == int'(n) - 1, rom_word(b + 10'(k))});
      q1.push_back({k == int'(n) - 1, rom_word(b + 10'(k))});
    end
    @(posedge clk); #1;
    start = 1; base_addr = b; word_cnt = n; start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 0; base_addr = 10'($urandom); word_cnt = 11'($urandom);
  endtask

  task automatic run_burst(input logic [9:0] b, input logic [10:0] n, input bit stall,
                           input bit poke, input bit hold_abort);
    int guard = 0;
    int stall_left = 0;
    m_ready = 1;
    abort = hold_abort;
    issue_start(b, n);
    while ((done_n[0] == 0 || done_n[1] == 0) && guard < 4000) begin
      if (stall_left > 0) begin
        m_ready = 0;
        stall_left--;
      end else begin
        m_ready = 1;
        if (stall && $urandom_range(0, 1) == 1) stall_left = $urandom_range(1, 10);
      end
      start = poke && guard == 4;
      @(posedge clk); #1;
      guard++;
    end
    start = 0; abort = 0; m_ready = 1;
    check("burst_timeout", 64'(guard >= 4000), 0);
    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 64'(q0.size()), 0);
    check("q1_drained", 64'(q1.size()), 0);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("done_once%0d", l), 64'(done_n[l]), 1);
      check($sformatf("done_timing%0d", l), 64'(done_cyc[l]),
            64'(n == 0 ? start_cyc + 1 : last_cyc[l] + 1));
      check($sformatf("busy_span%0d", l), 64'(busy_n[l]), 64'(done_cyc[l] - start_cyc));
      if (!stall && n != 0) begin
        // start is counted in the cycle it is driven, so latency L+1 shows up as L+2 here
        check($sformatf("first_latency%0d", l), 64'(first_cyc[l] - start_cyc), 64'(l + 3));
        check($sformatf("back_to_back%0d", l), 64'(last_cyc[l] - first_cyc[l]), 64'(n - 1));
      end
    end
    check("idle_after", 64'({busy0, busy1}), 0);
  endtask

  initial begin
    int guard;
    rst_n = 0; start = 0; abort = 0; base_addr = 0; word_cnt = 0; m_ready = 0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    rst_checks("por");
    rst_n = 1;
    @(posedge clk); #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    @(posedge clk); #1;
    check("abort_idle", 64'({busy0, busy1, m_valid0, m_valid1}), 0);
    run_burst(10'h010, 11'd8, 0, 0, 0);
    run_burst(10'h3FE, 11'd4, 0, 0, 0);
    run_burst(10'($urandom), 11'd16, 1, 1, 0);
    run_burst(10'($urandom), 11'd0, 0, 0, 1);
    // abort a 10-word burst after three beats
    m_ready = 1;
    issue_start(10'($urandom), 11'd10);
    guard = 0;
    while (hs_n[0] < 3 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_wait_timeout", 64'(guard >= 50), 0);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    @(negedge clk); #1;
    check("abort_flush", 64'({m_valid0, m_valid1, m_data0, m_data1}), 0);
    q0.delete();
    q1.delete();
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_n[0] + done_n[1]), 0);
    check("abort_idle_after", 64'({busy0, busy1}), 0);
    run_burst(10'($urandom), 11'd7, 0, 0, 0);
    // reset in the middle of a burst
    issue_start(10'($urandom), 11'd20);
    repeat (6) begin
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    rst_checks("mid_rst");
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_checks("held_rst");
    rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({busy0, busy1, m_valid0, m_valid1}), 0);
    run_burst(10'($urandom), 11'd12, 0, 0, 0);
    repeat (6) run_burst(10'($urandom), 11'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), 0, 0);
    run_burst(10'($urandom), 11'd1024, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
